agex_muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer attached beside the AGEX ALU.
- Accepts one MUL/DIV-class op from the DE latch contents and stalls FE/DE/AGEX while it iterates.
- Returns a 32-bit result for the AGEX latch `aluout` slot.
- Removes the single-cycle `*` from the AGEX critical path and adds RISC-V M-extension divide/remainder.

---
 rtl/agex_muldiv_ctrl_if.sv | 24 ++
 rtl/agex_muldiv_ctrl.sv | 154 +++++++++++++++
 tb/tb_agex_muldiv_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/agex_muldiv_ctrl_if.sv
// Request/response bundle between the AGEX stage and the multiply/divide sequencer.
// The requester (AGEX) drives start/op/operands/flush; the sequencer returns stall/done/result.
interface agex_muldiv_ctrl_if #(
  parameter int DBITS = 32
);
  logic             start;
  logic [2:0]       op;
  logic [DBITS-1:0] opa;
  logic [DBITS-1:0] opb;
  logic             flush;
  logic             stall_out;
  logic             done;
  logic [DBITS-1:0] result;

  modport master (
    output start, op, opa, opb, flush,
    input  stall_out, done, result
  );

  modport slave (
    input  start, op, opa, opb, flush,
    output stall_out, done, result
  );
endinterface

// File: rtl/agex_muldiv_ctrl.sv
// Multi-cycle MUL/MULHU/DIV/DIVU/REM/REMU sequencer beside the AGEX ALU (shift-add / restoring divide).
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divide path unchanged.
module agex_muldiv_ctrl #(
  parameter int DBITS   = 32,
  parameter int CNTBITS = 6
) (
  input logic               clk,
  input logic               reset,
  agex_muldiv_ctrl_if.slave bus
);

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULHU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_REM   = 3'd4;
  localparam logic [2:0] OP_REMU  = 3'd5;
  localparam logic [DBITS-1:0] MIN_NEG = {1'b1, {(DBITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [CNTBITS-1:0]     cnt;
  logic [2:0]             op_r;
  logic                   neg_q;
  logic                   neg_r;
  logic [2*DBITS-1:0]     acc;
  logic [DBITS-1:0]       dvsr;
  logic                   done_r;
  logic [DBITS-1:0]       result_r;

  function automatic logic [DBITS-1:0] neg_if(input logic [DBITS-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  logic             accept;
  logic             is_mul_in, is_sdiv_in, is_div_in, illegal_in;
  logic             sa, sb, div0, ovf;
  logic [DBITS-1:0] abs_a, abs_b, spec_res;

  assign accept        = (state == IDLE) && bus.start && !bus.flush;
  assign bus.stall_out = accept || (state == RUN);
  assign bus.done      = done_r;
  assign bus.result    = result_r;

  // Accept-cycle decode: magnitudes, sign flags and the single-cycle special results
  always_comb begin
    is_mul_in  = (bus.op == OP_MUL) || (bus.op == OP_MULHU);
    is_sdiv_in = (bus.op == OP_DIV) || (bus.op == OP_REM);
    is_div_in  = is_sdiv_in || (bus.op == OP_DIVU) || (bus.op == OP_REMU);
    illegal_in = !(is_mul_in || is_div_in);
    sa         = is_sdiv_in && bus.opa[DBITS-1];
    sb         = is_sdiv_in && bus.opb[DBITS-1];
    abs_a      = neg_if(bus.opa, sa);
    abs_b      = neg_if(bus.opb, sb);
    div0       = is_div_in && (bus.opb == '0);
    ovf        = is_sdiv_in && (bus.opa == MIN_NEG) && (bus.opb == '1);
    spec_res   = '0;
    if (div0)
      spec_res = ((bus.op == OP_DIV) || (bus.op == OP_DIVU)) ? '1 : bus.opa;
    else if (ovf)
      spec_res = (bus.op == OP_DIV) ? MIN_NEG : '0;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*DBITS-1:0] fast_prod;
  assign fast_prod = {{DBITS{1'b0}}, bus.opa} * {{DBITS{1'b0}}, bus.opb};
`endif

  logic [DBITS:0]     msum, dividend_w, trial;
  logic               fits;
  logic [2*DBITS-1:0] acc_nxt;
  logic [DBITS-1:0]   fin_res;

  // One iteration: acc holds {partial product hi, multiplier} or {remainder, quotient}
  always_comb begin
    msum       = {1'b0, acc[2*DBITS-1:DBITS]} + (acc[0] ? {1'b0, dvsr} : '0);
    dividend_w = {acc[2*DBITS-1:DBITS], acc[DBITS-1]};
    fits       = dividend_w >= {1'b0, dvsr};
    trial      = dividend_w - {1'b0, dvsr};
    if ((op_r == OP_MUL) || (op_r == OP_MULHU))
      acc_nxt = {msum, acc[DBITS-1:1]};
    else if (fits)
      acc_nxt = {trial[DBITS-1:0], acc[DBITS-2:0], 1'b1};
    else
      acc_nxt = {acc[2*DBITS-2:0], 1'b0};
    case (op_r)
      OP_MUL:          fin_res = acc_nxt[DBITS-1:0];
      OP_MULHU:        fin_res = acc_nxt[2*DBITS-1:DBITS];
      OP_DIV, OP_DIVU: fin_res = neg_if(acc_nxt[DBITS-1:0], neg_q);
      OP_REM, OP_REMU: fin_res = neg_if(acc_nxt[2*DBITS-1:DBITS], neg_r);
      default:         fin_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_r     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      acc      <= '0;
      dvsr     <= '0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else if (bus.flush) begin
      state  <= IDLE;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_r  <= bus.op;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            dvsr  <= is_mul_in ? bus.opb : abs_b;
            acc   <= {{DBITS{1'b0}}, (is_mul_in ? bus.opa : abs_a)};
            if (div0 || ovf || illegal_in) begin
              result_r <= spec_res;
              done_r   <= 1'b1;
              state    <= DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (is_mul_in) begin
              result_r <= (bus.op == OP_MUL) ? fast_prod[DBITS-1:0] : fast_prod[2*DBITS-1:DBITS];
              done_r   <= 1'b1;
              state    <= DONE;
            end
`endif
            else begin
              cnt   <= CNTBITS'(DBITS);
              state <= RUN;
            end
          end
        end
        // Iterate; the final step lands its sign-corrected result on DONE entry
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CNTBITS'(1)) begin
            result_r <= fin_res;
            done_r   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_agex_muldiv_ctrl.sv
// Directed plus randomized checks of agex_muldiv_ctrl against an arithmetic reference model.
module tb_agex_muldiv_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_res;

  agex_muldiv_ctrl_if #(.DBITS(32)) bus ();

  agex_muldiv_ctrl #(.DBITS(32), .CNTBITS(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = {32'b0, a} * {32'b0, b};
    case (o)
      3'd0: return p[31:0];
      3'd1: return p[63:32];
      3'd2: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd3: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd4: return (b == 0) ? a : 32'(sa % sb);
      3'd5: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o > 3'd5) return 1;
    if (o >= 3'd2 && b == 0) return 1;
    if ((o == 3'd2 || o == 3'd4) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (o <= 3'd1) return 1;
`endif
    return 33;
  endfunction

  // Entered and left at posedge+1; poke pulses a foreign start mid-iteration.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit poke);
    logic [31:0] er;
    int el, lat, stalls;
    bit seen;
    bit timed_out;
    er = ref_result(o, a, b);
    el = ref_latency(o, a, b);
    bus.start = 1'b1; bus.op = o; bus.opa = a; bus.opb = b;
    @(negedge clk);
    stalls = bus.stall_out ? 1 : 0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.opa = $urandom; bus.opb = $urandom;
    lat = 0; seen = 0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.done) seen = 1;
      else begin
        if (bus.stall_out) stalls++;
        if (poke && lat == 5) begin
          bus.start = 1'b1; bus.op = 3'd0; bus.opa = 32'd3; bus.opb = 32'd5;
        end else bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    timed_out = !seen;
    chk({tag, "/wait_expired"}, timed_out, 1'b0);
    chk({tag, "/done_seen"}, seen, 1'b1);
    chk({tag, "/latency"}, lat, el);
    chk({tag, "/result"}, bus.result, er);
    chk({tag, "/stall_in_done"}, bus.stall_out, 1'b0);
    chk({tag, "/stall_cycles"}, stalls, el);
    @(negedge clk);
    chk({tag, "/done_pulse"}, bus.done, 1'b0);
    chk({tag, "/result_held"}, bus.result, er);
    last_res = er;
    @(posedge clk); #1;
  endtask

  initial begin
    int ndone;
    logic [2:0]  o;
    logic [31:0] a, b;
    reset = 1'b1; bus.start = 1'b0; bus.flush = 1'b0;
    bus.op = 3'd0; bus.opa = '0; bus.opb = '0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset/done", bus.done, 1'b0);
    chk("reset/result", bus.result, 32'h0);
    chk("reset/stall", bus.stall_out, 1'b0);
    @(posedge clk); #1;

    run_op(3'd0, 32'd7, 32'd6, "mul", 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, "mulhu", 0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg", 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "rem_neg", 0);
    run_op(3'd3, 32'd100, 32'd7, "divu", 0);
    run_op(3'd5, 32'd100, 32'd7, "remu", 0);
    run_op(3'd3, 32'd5, 32'd0, "divu_by0", 0);
    run_op(3'd5, 32'd5, 32'd0, "remu_by0", 0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 0);
    run_op(3'd6, 32'd9, 32'd3, "illegal", 0);
    run_op(3'd3, 32'd1000, 32'd3, "start_in_run", 1);

    // flush together with start in IDLE: nothing accepted
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd3; bus.opa = 32'd100; bus.opb = 32'd7;
    @(negedge clk);
    chk("flush_start/stall", bus.stall_out, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_start/stall_next", bus.stall_out, 1'b0);
    chk("flush_start/done", bus.done, 1'b0);
    @(posedge clk); #1;

    // flush at RUN cycle 10, then restart one cycle later
    bus.start = 1'b1; bus.op = 3'd3; bus.opa = 32'd100; bus.opb = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush/stall", bus.stall_out, 1'b0);
    chk("flush/done", bus.done, 1'b0);
    chk("flush/result_kept", bus.result, last_res);
    @(posedge clk); #1;
    run_op(3'd3, 32'd100, 32'd7, "after_flush", 0);

    // reset held 2 cycles mid-RUN of a DIV
    bus.start = 1'b1; bus.op = 3'd2; bus.opa = 32'hFFFF_FFF9; bus.opb = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrun_reset/done", bus.done, 1'b0);
    chk("midrun_reset/result", bus.result, 32'h0);
    chk("midrun_reset/stall", bus.stall_out, 1'b0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("midrun_reset/no_done", ndone, 0);
    last_res = 32'h0;
    @(posedge clk); #1;

    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 200));
        default: ;
      endcase
      run_op(o, a, b, $sformatf("rand%0d_op%0d", i, o), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
